// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
//   Shares one 32-bit wait-state memory between NUM_MASTERS requesters.
//   Each master holds m_req until it gets a one-cycle m_ack (plus m_err on
//   timeout). The slave side is a held s_req / one-cycle s_ack handshake.
//   Grant is fixed-priority (ARB_MODE=0, lowest index wins) or round-robin
//   (ARB_MODE=1). All outputs are registered.
//
// Ports
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   m_req/m_we     per-master request and write enable
//   m_addr/m_wdata flattened per-master address and write data
//   m_wmask        flattened per-master byte mask {b3,b2,b1,b0}
//   m_ack/m_err    one-hot completion pulse and coincident timeout flag
//   m_rdata        read data, valid only while an m_ack bit is high
//   s_req..s_wmask slave request, held stable until s_ack or timeout
//   s_ack/s_rdata  slave completion pulse and read data
module rv32i_mem_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int ARB_MODE    = 0,
   parameter int TIMEOUT     = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS-1:0]        m_we,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_MASTERS*32-1:0]     m_wdata,
   input  logic [NUM_MASTERS*4-1:0]      m_wmask,
   output logic [NUM_MASTERS-1:0]        m_ack,
   output logic [NUM_MASTERS-1:0]        m_err,
   output logic [31:0]                   m_rdata,
   output logic                          s_req,
   output logic                          s_we,
   output logic [ADDR_WIDTH-1:0]         s_addr,
   output logic [31:0]                   s_wdata,
   output logic [3:0]                    s_wmask,
   input  logic                          s_ack,
   input  logic [31:0]                   s_rdata
);

   localparam int unsigned NM_U  = NUM_MASTERS;
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state;
   logic [IDX_W-1:0]     last_g;
   logic [IDX_W-1:0]     gnt_q;
   logic [CNT_W-1:0]     tmo_cnt;
   logic [IDX_W-1:0]     grant;
   logic [IDX_W-1:0]     cand;
   logic                 found;
   logic [NUM_MASTERS-1:0] gnt_onehot;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
   logic [31:0]           wdata_arr [NUM_MASTERS];
   logic [3:0]            wmask_arr [NUM_MASTERS];

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = m_wdata[gi*32 +: 32];
      assign wmask_arr[gi] = m_wmask[gi*4 +: 4];
   end

   // Round-robin walks last_g+1, last_g+2, ... modulo NUM_MASTERS; fixed
   // priority walks 0, 1, ... ; the first requester found in the walk wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NM_U; k++) begin
         if (ARB_MODE == 0)
            cand = IDX_W'(k);
         else
            cand = IDX_W'((32'(last_g) + k + 1) % NM_U);
         if (!found && m_req[cand]) begin
            grant = cand;
            found = 1'b1;
         end
      end
   end

   assign gnt_onehot = NUM_MASTERS'(1) << gnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         last_g  <= LAST_RST;
         gnt_q   <= '0;
         tmo_cnt <= '0;
         m_ack   <= '0;
         m_err   <= '0;
         m_rdata <= '0;
         s_req   <= 1'b0;
         s_we    <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_wmask <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  gnt_q   <= grant;
                  last_g  <= grant;
                  s_we    <= m_we[grant];
                  s_addr  <= addr_arr[grant];
                  s_wdata <= wdata_arr[grant];
                  s_wmask <= m_we[grant] ? wmask_arr[grant] : 4'h0;
                  s_req   <= 1'b1;
                  tmo_cnt <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               // s_ack is tested first so it wins over a coincident timeout.
               if (s_ack) begin
                  s_req   <= 1'b0;
                  m_ack   <= gnt_onehot;
                  m_rdata <= s_we ? 32'h0 : s_rdata;
                  state   <= DONE;
               end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                  s_req   <= 1'b0;
                  m_ack   <= gnt_onehot;
                  m_err   <= gnt_onehot;
                  m_rdata <= '0;
                  state   <= DONE;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DONE: begin
               m_ack   <= '0;
               m_err   <= '0;
               m_rdata <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter
//   Two 3-master arbiters: dut_a round-robin with TIMEOUT=4, dut_b fixed
//   priority with TIMEOUT=3. Master-side address/data/mask and the slave
//   s_ack/s_rdata are shared; each DUT has its own m_req so only the DUT
//   under test is active at a time.
module tb_rv32i_mem_arbiter;

   localparam int NM = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NM-1:0]   req_a, req_b, m_we;
   logic [NM*32-1:0] m_addr, m_wdata;
   logic [NM*4-1:0] m_wmask;
   logic            s_ack;
   logic [31:0]     s_rdata;

   logic [NM-1:0] ack_a, err_a, ack_b, err_b;
   logic [31:0]   rdata_a, rdata_b, saddr_a, saddr_b, swdata_a, swdata_b;
   logic          sreq_a, sreq_b, swe_a, swe_b;
   logic [3:0]    swmask_a, swmask_b;

   rv32i_mem_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(32), .ARB_MODE(1), .TIMEOUT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .m_req(req_a), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wmask(m_wmask), .m_ack(ack_a), .m_err(err_a),
      .m_rdata(rdata_a), .s_req(sreq_a), .s_we(swe_a), .s_addr(saddr_a),
      .s_wdata(swdata_a), .s_wmask(swmask_a), .s_ack(s_ack), .s_rdata(s_rdata));

   rv32i_mem_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(32), .ARB_MODE(0), .TIMEOUT(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .m_req(req_b), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wmask(m_wmask), .m_ack(ack_b), .m_err(err_b),
      .m_rdata(rdata_b), .s_req(sreq_b), .s_we(swe_b), .s_addr(saddr_b),
      .s_wdata(swdata_b), .s_wmask(swmask_b), .s_ack(s_ack), .s_rdata(s_rdata));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NM-1:0] ack, err;
      logic [31:0]   rdata;
      logic          sreq, swe;
      logic [31:0]   saddr, swdata;
      logic [3:0]    swmask;
   } out_t;

   // d: number of BUSY cycles before s_ack (99 = never); exp_cyc: BUSY
   // edges from grant until m_ack is visible.
   typedef struct {
      int          sel;
      int          master;
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  wmask;
      int          d;
      logic [31:0] rdin;
      int          exp_cyc;
      logic [3:0]  exp_swmask;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic out_t get_out(input int sel);
      out_t o;
      if (sel == 0) begin
         o.ack = ack_a; o.err = err_a; o.rdata = rdata_a; o.sreq = sreq_a; o.swe = swe_a;
         o.saddr = saddr_a; o.swdata = swdata_a; o.swmask = swmask_a;
      end else begin
         o.ack = ack_b; o.err = err_b; o.rdata = rdata_b; o.sreq = sreq_b; o.swe = swe_b;
         o.saddr = saddr_b; o.swdata = swdata_b; o.swmask = swmask_b;
      end
      return o;
   endfunction

   function automatic int onehot_idx(input logic [NM-1:0] v);
      if (v == 3'b001) return 0;
      if (v == 3'b010) return 1;
      if (v == 3'b100) return 2;
      return 99;
   endfunction

   task automatic set_req(input int sel, input logic [NM-1:0] v);
      if (sel == 0) req_a = v;
      else          req_b = v;
   endtask

   // Master m gets the given fields; every other master gets the inverse so
   // a wrong mux selection is visible on s_*.
   task automatic drive(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask);
      for (int i = 0; i < NM; i++) begin
         m_we[i]            = ~we;
         m_addr[i*32 +: 32] = ~addr;
         m_wdata[i*32 +: 32] = ~wdata;
         m_wmask[i*4 +: 4]  = ~wmask;
      end
      m_we[m]            = we;
      m_addr[m*32 +: 32] = addr;
      m_wdata[m*32 +: 32] = wdata;
      m_wmask[m*4 +: 4]  = wmask;
   endtask

   task automatic check_zero(input int sel, input string tag);
      out_t o;
      o = get_out(sel);
      check({tag, " m_ack"},   32'(o.ack),    32'h0);
      check({tag, " m_err"},   32'(o.err),    32'h0);
      check({tag, " m_rdata"}, o.rdata,       32'h0);
      check({tag, " s_req"},   32'(o.sreq),   32'h0);
      check({tag, " s_we"},    32'(o.swe),    32'h0);
      check({tag, " s_addr"},  o.saddr,       32'h0);
      check({tag, " s_wdata"}, o.swdata,      32'h0);
      check({tag, " s_wmask"}, 32'(o.swmask), 32'h0);
   endtask

   task automatic run_vec(input vec_t v, input int n);
      out_t          o;
      int            cyc;
      bit            done;
      logic [NM-1:0] one;
      string         tag;
      tag = $sformatf("v%0d", n);
      one = 3'b001 << v.master;
      drive(v.master, v.we, v.addr, v.wdata, v.wmask);
      set_req(v.sel, one);
      @(posedge clk); #1;
      o = get_out(v.sel);
      check({tag, " s_req"},   32'(o.sreq),   32'h1);
      check({tag, " s_addr"},  o.saddr,       v.addr);
      check({tag, " s_we"},    32'(o.swe),    32'(v.we));
      check({tag, " s_wdata"}, o.swdata,      v.wdata);
      check({tag, " s_wmask"}, 32'(o.swmask), 32'(v.exp_swmask));
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 10) begin
         cyc++;
         s_ack   = (cyc == v.d + 1);
         s_rdata = s_ack ? v.rdin : 32'hBAD0_BAD0;
         @(posedge clk); #1;
         s_ack = 1'b0;
         o = get_out(v.sel);
         if (o.ack != '0) done = 1'b1;
         else check({tag, " s_req held"}, 32'(o.sreq), 32'h1);
      end
      check({tag, " ack seen"},   32'(done),  32'h1);
      check({tag, " ack cycle"},  32'(cyc),   32'(v.exp_cyc));
      check({tag, " m_ack"},      32'(o.ack), 32'(one));
      check({tag, " m_err"},      32'(o.err), v.exp_err ? 32'(one) : 32'h0);
      check({tag, " m_rdata"},    o.rdata,    v.exp_rdata);
      check({tag, " s_req drop"}, 32'(o.sreq), 32'h0);
      set_req(v.sel, '0);
      @(posedge clk); #1;
      o = get_out(v.sel);
      check({tag, " ack clear"},   32'(o.ack), 32'h0);
      check({tag, " err clear"},   32'(o.err), 32'h0);
      check({tag, " rdata clear"}, o.rdata,    32'h0);
      @(posedge clk); #1;
   endtask

   vec_t vecs[7];
   int   ga[6];
   int   gb[6];
   int   na, nb, cyc;
   out_t o;

   initial begin
      vecs[0] = '{0, 1, 1'b0, 32'h0000_2000, 32'hAAAA_5555, 4'hF,    2, 32'hDEAD_BEEF, 3, 4'h0,    1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{0, 0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0, 32'hCAFE_F00D, 1, 4'b0011, 1'b0, 32'h0};
      vecs[2] = '{0, 2, 1'b0, 32'h8000_0004, 32'h0F0F_0F0F, 4'hC,    3, 32'h0BAD_F00D, 4, 4'h0,    1'b0, 32'h0BAD_F00D};
      vecs[3] = '{0, 1, 1'b0, 32'h0000_3000, 32'h0000_0000, 4'hF,   99, 32'h1111_1111, 4, 4'h0,    1'b1, 32'h0};
      vecs[4] = '{1, 1, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0,    2, 32'h5A5A_1234, 3, 4'h0,    1'b0, 32'h5A5A_1234};
      vecs[5] = '{1, 2, 1'b1, 32'h0000_0044, 32'hFFEE_0011, 4'b1000,99, 32'h2222_2222, 3, 4'b1000, 1'b1, 32'h0};
      vecs[6] = '{1, 0, 1'b0, 32'h0000_0048, 32'h0000_0000, 4'h5,    1, 32'h7654_3210, 2, 4'h0,    1'b0, 32'h7654_3210};

      rst_n = 1'b0; req_a = '0; req_b = '0; m_we = '0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; s_ack = 1'b0; s_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero(0, "reset a");
      check_zero(1, "reset b");
      rst_n = 1'b1;

      // Arbitration order: all masters request, each drops for one cycle
      // after its ack; slave acks immediately.
      drive(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      s_ack = 1'b1; s_rdata = 32'h1357_9BDF;
      req_a = '1; req_b = '1;
      na = 0; nb = 0; cyc = 0;
      while ((na < 6 || nb < 6) && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (ack_a != '0 && na < 6) begin ga[na] = onehot_idx(ack_a); na++; end
         if (ack_b != '0 && nb < 6) begin gb[nb] = onehot_idx(ack_b); nb++; end
         req_a = ~ack_a;
         req_b = ~ack_b;
      end
      s_ack = 1'b0;
      req_a = '0; req_b = '0;
      for (int i = na; i < 6; i++) ga[i] = -1;
      for (int i = nb; i < 6; i++) gb[i] = -1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rr grant %0d", i),    32'(ga[i]), 32'(i % 3));
         check($sformatf("fixed grant %0d", i), 32'(gb[i]), 32'h0);
      end
      repeat (2) @(posedge clk);
      #1;

      for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

      // Timeout followed by late s_ack in DONE and a spurious one in IDLE.
      drive(0, 1'b0, 32'h0000_0A00, 32'h0, 4'hF);
      req_a = 3'b001;
      @(posedge clk); #1;
      check("tmo s_req", 32'(sreq_a), 32'h1);
      cyc = 0;
      while (ack_a == '0 && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("tmo cycle", 32'(cyc),   32'h4);
      check("tmo m_ack", 32'(ack_a), 32'h1);
      check("tmo m_err", 32'(err_a), 32'h1);
      check("tmo rdata", rdata_a,    32'h0);
      check("tmo s_req", 32'(sreq_a), 32'h0);
      req_a = '0;
      s_ack = 1'b1; s_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("late ack m_ack", 32'(ack_a),  32'h0);
      check("late ack m_err", 32'(err_a),  32'h0);
      check("late ack rdata", rdata_a,     32'h0);
      check("late ack s_req", 32'(sreq_a), 32'h0);
      @(posedge clk); #1;
      check("idle ack m_ack", 32'(ack_a),  32'h0);
      check("idle ack s_req", 32'(sreq_a), 32'h0);
      check("idle ack rdata", rdata_a,     32'h0);
      s_ack = 1'b0;

      // Reset while BUSY, then the still-pending master 1 is serviced.
      drive(1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
      req_a = 3'b010;
      @(posedge clk); #1;
      check("rst busy s_req", 32'(sreq_a), 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_zero(0, "rst busy");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post rst s_req",  32'(sreq_a), 32'h1);
      check("post rst s_addr", saddr_a,     32'h0000_0300);
      s_ack = 1'b1; s_rdata = 32'h600D_CAFE;
      @(posedge clk); #1;
      s_ack = 1'b0;
      check("post rst m_ack", 32'(ack_a), 32'h2);
      check("post rst m_err", 32'(err_a), 32'h0);
      check("post rst rdata", rdata_a,    32'h600D_CAFE);
      req_a = '0;
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
